// File: rtl/kb_event_scheduler_pkg.sv
// Shared constants, types and helpers for the keyboard/mouse event scheduler.
package kb_pkg;
  localparam logic SRC_KEYBOARD = 1'b0;
  localparam logic SRC_MOUSE    = 1'b1;

  localparam int DROP_W            = 8;
  localparam int KB_DEPTH_DEF      = 8;
  localparam int MS_DEPTH_DEF      = 4;
  localparam int MAX_KB_STREAK_DEF = 4;

  typedef struct packed {
    logic        is_mouse;
    logic [15:0] data;
  } kb_evt_t;

  // Saturating +1 for the drop counters.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction
endpackage

// File: rtl/kb_event_scheduler_if.sv
// Poller-side and host-side signals of the scheduler.
// slave = the scheduler, master = the environment driving it.
interface kb_event_scheduler_if;
  logic        kb_data_ready;
  logic        kb_is_mouse;
  logic [15:0] kb_data;
  logic        kb_data_retrieved;
  logic        host_enable;
  logic        out_valid;
  logic        out_is_mouse;
  logic [15:0] out_data;
  logic        out_ready;

  modport slave (
    input  kb_data_ready, kb_is_mouse, kb_data, host_enable, out_ready,
    output kb_data_retrieved, out_valid, out_is_mouse, out_data
  );
  modport master (
    output kb_data_ready, kb_is_mouse, kb_data, host_enable, out_ready,
    input  kb_data_retrieved, out_valid, out_is_mouse, out_data
  );
endinterface

// File: rtl/kb_event_scheduler_fifo.sv
// 16-bit synchronous FIFO, power-of-two depth, show-ahead read port.
// Pointers carry one extra wrap bit; a push while full is taken only
// when the same cycle also pops.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = KB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_push,
  input  logic [15:0] i_data,
  input  logic        i_pop,
  output logic [15:0] o_data,
  output logic        o_full,
  output logic        o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        w_do_push, w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  // Storage array, no reset needed: pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  // Read/write pointers with natural wrap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/kb_event_scheduler.sv
// Drains the poller buffer into per-source FIFOs and hands one event at a
// time to the host, keyboard first but with a bounded keyboard streak.
module kb_event_scheduler
  import kb_pkg::*;
#(
  parameter int KB_DEPTH      = KB_DEPTH_DEF,
  parameter int MS_DEPTH      = MS_DEPTH_DEF,
  parameter int MAX_KB_STREAK = MAX_KB_STREAK_DEF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  kb_event_scheduler_if.slave   io,
  output logic [DROP_W-1:0]     kb_drop_count,
  output logic [DROP_W-1:0]     ms_drop_count
);
  localparam int          SW         = $clog2(MAX_KB_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_KB_STREAK);

  logic              r_lockout;
  logic [SW-1:0]     r_streak;
  logic              r_out_valid, r_out_is_mouse;
  logic [15:0]       r_out_data;
  logic [DROP_W-1:0] r_kb_drop, r_ms_drop;

  logic        w_capture, w_kb_push, w_ms_push;
  logic        w_kb_full, w_kb_empty, w_ms_full, w_ms_empty;
  logic [15:0] w_kb_data, w_ms_data;
  logic        w_accept, w_load, w_grant_kb, w_grant_ms;

  // The retrieve pulse is held off during reset so the poller buffer is
  // left alone; lockout hides the poller's one-cycle-late ready clear.
  assign w_capture = io.kb_data_ready && !r_lockout && n_reset;
  assign w_kb_push = w_capture && (io.kb_is_mouse == SRC_KEYBOARD);
  assign w_ms_push = w_capture && (io.kb_is_mouse == SRC_MOUSE);

  assign w_accept   = r_out_valid && io.out_ready;
  assign w_load     = (!r_out_valid || w_accept) && io.host_enable &&
                      (!w_kb_empty || !w_ms_empty);
  assign w_grant_kb = !w_kb_empty && (w_ms_empty || (r_streak < STREAK_MAX));
  assign w_grant_ms = !w_ms_empty && !w_grant_kb;

  kb_event_fifo #(.DEPTH(KB_DEPTH)) u_kb_fifo (
    .clk(clk), .n_reset(n_reset),
    .i_push(w_kb_push), .i_data(io.kb_data), .i_pop(w_load && w_grant_kb),
    .o_data(w_kb_data), .o_full(w_kb_full), .o_empty(w_kb_empty)
  );

  kb_event_fifo #(.DEPTH(MS_DEPTH)) u_ms_fifo (
    .clk(clk), .n_reset(n_reset),
    .i_push(w_ms_push), .i_data(io.kb_data), .i_pop(w_load && w_grant_ms),
    .o_data(w_ms_data), .o_full(w_ms_full), .o_empty(w_ms_empty)
  );

  // Capture lockout: set for exactly the cycle after a retrieve.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_lockout <= 1'b0;
    else          r_lockout <= w_capture;
  end

  // Output stage and keyboard streak; data holds until accepted.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_out_valid    <= 1'b0;
      r_out_is_mouse <= 1'b0;
      r_out_data     <= '0;
      r_streak       <= '0;
    end else if (w_load) begin
      r_out_valid    <= 1'b1;
      r_out_is_mouse <= w_grant_kb ? SRC_KEYBOARD : SRC_MOUSE;
      r_out_data     <= w_grant_kb ? w_kb_data : w_ms_data;
      if (w_grant_kb) r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
      else            r_streak <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // Drop counters: a retrieved event that finds its FIFO full and not popping.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_kb_drop <= '0;
      r_ms_drop <= '0;
    end else begin
      if (w_kb_push && w_kb_full && !(w_load && w_grant_kb)) r_kb_drop <= sat_inc(r_kb_drop);
      if (w_ms_push && w_ms_full && !(w_load && w_grant_ms)) r_ms_drop <= sat_inc(r_ms_drop);
    end
  end

  assign io.kb_data_retrieved = w_capture;
  assign io.out_valid         = r_out_valid;
  assign io.out_is_mouse      = r_out_is_mouse;
  assign io.out_data          = r_out_data;
  assign kb_drop_count        = r_kb_drop;
  assign ms_drop_count        = r_ms_drop;
endmodule
